// File: rtl/memory_game_ctrl.sv
// memory_game_ctrl: hit-tests clicks on a 4x2 tile grid and sequences flip/compare/hide
// for an 8-tile memory game; face_up selects image (1) or background (0) per tile.
module memory_game_ctrl #(
    parameter int N_COLS      = 4,
    parameter int N_ROWS      = 2,
    parameter int X0          = 100,
    parameter int Y0          = 100,
    parameter int A_SIDE      = 150,
    parameter int B_SIDE      = 200,
    parameter int GAP         = 40,
    parameter int SHOW_CYCLES = 65_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MouseLeft,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    input  logic [23:0] card_id,
    input  logic        new_game,
    output logic [7:0]  face_up,
    output logic [7:0]  matched,
    output logic [7:0]  moves,
    output logic        game_done
);
    localparam int CW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, ONE_UP, COMPARE, SHOW, CHECK, DONE} state_t;

    state_t        state;
    logic          mouse_q;
    logic [CW-1:0] cnt;
    logic [2:0]    first;
    logic [2:0]    second;
    logic [12:0]   x;
    logic [12:0]   y;
    logic          hit;
    logic [2:0]    hit_idx;
    logic          pick;

    assign x = {1'b0, xpos};
    assign y = {1'b0, ypos};

    // 13-bit bounds keep X0+offset+A_SIDE from wrapping
    always_comb begin
        hit = 1'b0;
        hit_idx = '0;
        for (int r = 0; r < N_ROWS; r++)
            for (int c = 0; c < N_COLS; c++)
                if (x >= 13'(X0 + c*(A_SIDE+GAP)) && x <= 13'(X0 + c*(A_SIDE+GAP) + A_SIDE) &&
                    y >= 13'(Y0 + r*(B_SIDE+GAP)) && y <= 13'(Y0 + r*(B_SIDE+GAP) + B_SIDE)) begin
                    hit = 1'b1;
                    hit_idx = 3'(r*N_COLS + c);
                end
    end

    assign pick = MouseLeft & ~mouse_q & hit & ~matched[hit_idx] & ~face_up[hit_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mouse_q   <= 1'b0;
            face_up   <= '0;
            matched   <= '0;
            moves     <= '0;
            game_done <= 1'b0;
            cnt       <= '0;
            first     <= '0;
            second    <= '0;
        end else begin
            mouse_q <= MouseLeft;
            if (new_game) begin
                state     <= IDLE;
                face_up   <= '0;
                matched   <= '0;
                moves     <= '0;
                game_done <= 1'b0;
                cnt       <= '0;
            end else begin
                case (state)
                    IDLE: if (pick) begin
                        face_up[hit_idx] <= 1'b1;
                        first <= hit_idx;
                        state <= ONE_UP;
                    end
                    ONE_UP: if (pick) begin
                        face_up[hit_idx] <= 1'b1;
                        second <= hit_idx;
                        state <= COMPARE;
                    end
                    COMPARE: begin
                        moves <= moves + 8'(moves != 8'hFF);
                        if (card_id[3*first +: 3] == card_id[3*second +: 3]) begin
                            matched[first]  <= 1'b1;
                            matched[second] <= 1'b1;
                            state <= CHECK;
                        end else begin
                            cnt   <= CW'(SHOW_CYCLES - 1);
                            state <= SHOW;
                        end
                    end
                    SHOW: if (cnt == '0) begin
                        face_up[first]  <= 1'b0;
                        face_up[second] <= 1'b0;
                        state <= IDLE;
                    end else
                        cnt <= cnt - 1'b1;
                    CHECK: begin
                        game_done <= &matched;
                        state <= (&matched) ? DONE : IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
